sb_reg_initiator: RTL and testbench

Sideband register-access initiator: the requesting end of the `sb_registers` access bus. Accepts single read or 1–3-byte write requests from the link-training/control logic over a valid/ready handshake. Serialises writes into per-byte register-file write cycles, issues reads and captures the 24-bit `sb_read` word. Returns a one-cycle response pulse per request.

---
 rtl/sb_reg_initiator.sv | 150 +++++++++++++++
 tb/tb_sb_reg_initiator.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/sb_reg_initiator.sv
// Sideband register-access initiator: turns valid/ready read and 1-3 byte write
// requests into sb_registers bus cycles. Optional range check: SB_INIT_RANGE_CHECK_EN.
module sb_reg_initiator #(
  parameter int MAX_ADDR = 156
) (
  input  logic        sb_clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [7:0]  req_addr,
  input  logic [1:0]  req_len,
  input  logic [23:0] req_wdata,
  output logic        rsp_valid,
  output logic [23:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        s_read_o_s_write_0,
  output logic [7:0]  s_address_o,
  output logic [7:0]  s_data_o,
  input  logic [23:0] sb_read
);

`ifdef SB_INIT_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif
  localparam logic [8:0] MAX9 = 9'(MAX_ADDR);

  typedef enum logic [2:0] {IDLE, WRITE, RD_ISSUE, RD_WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [1:0]  len_q;
  logic [23:0] wdata_q;
  logic [1:0]  k_q, k_d;
  logic        rdy_q, rdy_d;
  logic        wr_n_d, rsp_valid_d, rsp_err_d, busy_d;
  logic [7:0]  addr_d, data_d;
  logic [23:0] rdata_d;

  logic        accept, wr_bad, rd_bad, last_byte;
  logic [8:0]  wr_end;

  function automatic logic [7:0] wbyte(input logic [23:0] w, input logic [1:0] i);
    case (i)
      2'd0:    wbyte = w[7:0];
      2'd1:    wbyte = w[15:8];
      default: wbyte = w[23:16];
    endcase
  endfunction

  // The registered ready is masked while rst is high so nothing is taken during reset
  assign req_ready = rdy_q && !rst;
  assign accept    = req_valid && req_ready;
  assign wr_end    = {1'b0, req_addr} + {7'd0, req_len} - 9'd1;
  assign wr_bad    = (req_len == 2'd0) || (RANGE_EN && (wr_end > MAX9));
  assign rd_bad    = RANGE_EN && ({1'b0, req_addr} > MAX9);
  assign last_byte = (k_q == len_q - 2'd1);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_write) state_d = wr_bad ? RESP : WRITE;
          else           state_d = rd_bad ? RESP : RD_ISSUE;
        end
      end
      WRITE:    state_d = last_byte ? RESP : WRITE;
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT:  state_d = RESP;
      RESP:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Next values for the output registers, so every port reflects the state it enters
  always_comb begin
    k_d         = k_q;
    wr_n_d      = 1'b1;
    addr_d      = s_address_o;
    data_d      = s_data_o;
    rdata_d     = rsp_rdata;
    rsp_valid_d = (state_d == RESP);
    rsp_err_d   = 1'b0;
    rdy_d       = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_write && !wr_bad) begin
            wr_n_d = 1'b0;
            addr_d = req_addr;
            data_d = req_wdata[7:0];
            k_d    = 2'd0;
          end else if (!req_write && !rd_bad) begin
            addr_d = req_addr;
          end else begin
            rsp_err_d = 1'b1;
          end
        end
      end
      WRITE: begin
        if (!last_byte) begin
          k_d    = k_q + 2'd1;
          wr_n_d = 1'b0;
          addr_d = s_address_o + 8'd1;
          data_d = wbyte(wdata_q, k_q + 2'd1);
        end
      end
      RD_WAIT: rdata_d = sb_read;
      default: ;
    endcase
  end

  always_ff @(posedge sb_clk) begin
    if (rst) begin
      state_q            <= IDLE;
      k_q                <= 2'd0;
      rdy_q              <= 1'b1;
      s_read_o_s_write_0 <= 1'b1;
      s_address_o        <= 8'd0;
      s_data_o           <= 8'd0;
      rsp_valid          <= 1'b0;
      rsp_rdata          <= 24'd0;
      rsp_err            <= 1'b0;
      busy               <= 1'b0;
    end else begin
      state_q            <= state_d;
      k_q                <= k_d;
      rdy_q              <= rdy_d;
      s_read_o_s_write_0 <= wr_n_d;
      s_address_o        <= addr_d;
      s_data_o           <= data_d;
      rsp_valid          <= rsp_valid_d;
      rsp_rdata          <= rdata_d;
      rsp_err            <= rsp_err_d;
      busy               <= busy_d;
    end
  end

  always_ff @(posedge sb_clk) begin
    if (accept) begin
      len_q   <= req_len;
      wdata_q <= req_wdata;
    end
  end

endmodule

// File: tb/tb_sb_reg_initiator.sv
// Directed bench for sb_reg_initiator with a simple registered register-file model.
module tb_sb_reg_initiator;
  logic        sb_clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [7:0]  req_addr = 8'd0;
  logic [1:0]  req_len = 2'd0;
  logic [23:0] req_wdata = 24'd0;
  logic        rsp_valid;
  logic [23:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic        s_read_o_s_write_0;
  logic [7:0]  s_address_o;
  logic [7:0]  s_data_o;
  logic [23:0] sb_read = 24'd0;

  int checks = 0;
  int errors = 0;
  int nwrites = 0;
  logic [7:0] mem [256];

  sb_reg_initiator #(.MAX_ADDR(156)) dut (
    .sb_clk(sb_clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_len(req_len),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy), .s_read_o_s_write_0(s_read_o_s_write_0),
    .s_address_o(s_address_o), .s_data_o(s_data_o), .sb_read(sb_read)
  );

  always #5 sb_clk = ~sb_clk;

  initial for (int i = 0; i < 256; i++) mem[i] = 8'd0;

  // Register file: writes when the command line is low, registered 3-byte read word
  always @(posedge sb_clk) begin
    if (!s_read_o_s_write_0) begin
      mem[s_address_o] <= s_data_o;
      nwrites <= nwrites + 1;
    end
    sb_read <= {mem[s_address_o + 8'd2], mem[s_address_o + 8'd1], mem[s_address_o]};
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge sb_clk); #1;
  endtask

  task automatic accept(input logic w, input logic [7:0] a, input logic [1:0] l,
                        input logic [23:0] d);
    int n = 0;
    while (!req_ready && n < 20) begin step(); n++; end
    check_eq("ready_before_req", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = w; req_addr = a; req_len = l; req_wdata = d;
    step();
    req_valid = 1'b0;
    req_wdata = 24'hFFFFFF;
  endtask

  task automatic write_ok(input logic [7:0] a, input logic [1:0] l, input logic [23:0] d);
    int w0 = nwrites;
    logic [23:0] sh;
    accept(1'b1, a, l, d);
    sh = d;
    for (int i = 0; i < int'(l); i++) begin
      check_eq("wr_cmd", {31'd0, s_read_o_s_write_0}, 32'd0);
      check_eq("wr_addr", {24'd0, s_address_o}, {24'd0, a + 8'(i)});
      check_eq("wr_data", {24'd0, s_data_o}, {24'd0, sh[7:0]});
      check_eq("wr_no_rsp", {31'd0, rsp_valid}, 32'd0);
      sh = sh >> 8;
      step();
    end
    check_eq("wr_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check_eq("wr_rsp_err", {31'd0, rsp_err}, 32'd0);
    check_eq("wr_rsp_cmd", {31'd0, s_read_o_s_write_0}, 32'd1);
    step();
    check_eq("wr_rsp_pulse", {31'd0, rsp_valid}, 32'd0);
    check_eq("wr_ready_again", {31'd0, req_ready}, 32'd1);
    check_eq("wr_count", nwrites - w0, 32'(l));
  endtask

  task automatic reject(input logic w, input logic [7:0] a, input logic [1:0] l,
                        input logic [23:0] d);
    int w0 = nwrites;
    accept(w, a, l, d);
    check_eq("rej_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check_eq("rej_rsp_err", {31'd0, rsp_err}, 32'd1);
    check_eq("rej_cmd", {31'd0, s_read_o_s_write_0}, 32'd1);
    step();
    check_eq("rej_rsp_pulse", {31'd0, rsp_valid}, 32'd0);
    check_eq("rej_ready", {31'd0, req_ready}, 32'd1);
    check_eq("rej_no_writes", nwrites - w0, 32'd0);
  endtask

  task automatic read_ok(input logic [7:0] a, input logic [23:0] exp);
    int w0 = nwrites;
    accept(1'b0, a, 2'd0, 24'd0);
    check_eq("rd_issue_cmd", {31'd0, s_read_o_s_write_0}, 32'd1);
    check_eq("rd_issue_addr", {24'd0, s_address_o}, {24'd0, a});
    check_eq("rd_issue_busy", {31'd0, busy}, 32'd1);
    step();
    check_eq("rd_wait_cmd", {31'd0, s_read_o_s_write_0}, 32'd1);
    check_eq("rd_wait_no_rsp", {31'd0, rsp_valid}, 32'd0);
    step();
    check_eq("rd_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check_eq("rd_rsp_err", {31'd0, rsp_err}, 32'd0);
    check_eq("rd_rdata", {8'd0, rsp_rdata}, {8'd0, exp});
    step();
    check_eq("rd_ready_again", {31'd0, req_ready}, 32'd1);
    check_eq("rd_rdata_hold", {8'd0, rsp_rdata}, {8'd0, exp});
    check_eq("rd_no_writes", nwrites - w0, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) begin
      step();
      check_eq("rst_cmd", {31'd0, s_read_o_s_write_0}, 32'd1);
      check_eq("rst_ready_low", {31'd0, req_ready}, 32'd0);
      check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    end
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_addr", {24'd0, s_address_o}, 32'd0);
    check_eq("rst_data", {24'd0, s_data_o}, 32'd0);
    check_eq("rst_rdata", {8'd0, rsp_rdata}, 32'd0);
    check_eq("rst_err", {31'd0, rsp_err}, 32'd0);
    rst = 1'b0;
    step();
    check_eq("post_rst_ready", {31'd0, req_ready}, 32'd1);

    write_ok(8'd78, 2'd3, 24'h050333);
    check_eq("idle_addr_hold", {24'd0, s_address_o}, 32'd80);
    check_eq("idle_data_hold", {24'd0, s_data_o}, 32'h05);
    read_ok(8'd78, 24'h050333);
    reject(1'b1, 8'd10, 2'd0, 24'h123456);
`ifdef SB_INIT_RANGE_CHECK_EN
    reject(1'b1, 8'd155, 2'd3, 24'hA3A2A1);
    reject(1'b0, 8'd200, 2'd0, 24'd0);
    write_ok(8'd154, 2'd3, 24'hB3B2B1);
`else
    write_ok(8'd155, 2'd3, 24'hA3A2A1);
    check_eq("mem157", {24'd0, mem[157]}, 32'hA3);
    write_ok(8'd255, 2'd2, 24'h002211);
    check_eq("mem255", {24'd0, mem[255]}, 32'h11);
    check_eq("mem0_wrap", {24'd0, mem[0]}, 32'h22);
`endif
    write_ok(8'h40, 2'd1, 24'h0000AB);
    read_ok(8'h40, 24'h0000AB);

    // Reset while the second of three bytes is on the bus
    accept(1'b1, 8'd20, 2'd3, 24'hCCBBAA);
    check_eq("mid_b0_addr", {24'd0, s_address_o}, 32'd20);
    step();
    check_eq("mid_b1_cmd", {31'd0, s_read_o_s_write_0}, 32'd0);
    rst = 1'b1;
    step();
    check_eq("mid_rst_cmd", {31'd0, s_read_o_s_write_0}, 32'd1);
    check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("mid_rst_ready_low", {31'd0, req_ready}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("mid_no_rsp", {31'd0, rsp_valid}, 32'd0);
      check_eq("mid_idle_cmd", {31'd0, s_read_o_s_write_0}, 32'd1);
    end
    check_eq("mid_ready", {31'd0, req_ready}, 32'd1);
    check_eq("mid_byte0_kept", {24'd0, mem[20]}, 32'hAA);
    check_eq("mid_no_byte2", {24'd0, mem[22]}, 32'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
